kmap_sweep_ctrl: RTL and testbench
==================================

KMAP_SWEEP_CTRL -- requirements
Module: kmap_sweep_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE, default 1, meaning the number of clock cycles each input vector is held before its evaluator output is sampled (legal range 1..15).
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  begin sweep; sampled only in IDLE.
REQ-006 abort  input  1  synchronous sweep cancel; has priority over all other transitions except rst.
REQ-007 exp_tt  input  16  expected truth table; bit i is the expected f for vector i.
REQ-008 f_in  input  1  output of the external 4-variable combinational evaluator.
REQ-009 x1, x2, x3, x4  output  1 each  registered evaluator inputs; {x1,x2,x3,x4} = idx, with x1 as the MSB.
REQ-010 busy  output  1  high in WAIT and SAMPLE.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 tt  output  16  captured truth table.
REQ-013 ones  output  5  count of vectors with f_in=1 (range 0..16).
REQ-014 mismatch  output  1  sticky; high if any captured bit differs from exp_tt.
REQ-015 err_idx  output  4  index of the first mismatching vector.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT, SAMPLE and FIN.
REQ-017 In IDLE with start=1 and abort=0, SHALL:
- clear idx, the settle counter, tt, ones, mismatch and err_idx;
- go to WAIT.
REQ-018 In WAIT, SHALL hold x1..x4 = idx and count SETTLE cycles, then go to SAMPLE.
REQ-019 In SAMPLE, SHALL:
- set tt[idx] <= f_in;
- set ones <= ones + f_in;
- if f_in != exp_tt[idx] and mismatch=0, set mismatch <= 1 and err_idx <= idx.
REQ-020 From SAMPLE, if idx=15 SHALL go to FIN; otherwise SHALL increment idx and return to WAIT.
REQ-021 idx SHALL never wrap during a sweep; after idx 15 is sampled, x1..x4 SHALL hold 4'b1111 until the next start.
REQ-022 In FIN, SHALL assert done for exactly one cycle, then go to IDLE.
REQ-023 Each vector SHALL take SETTLE+1 cycles.
REQ-024 done SHALL be high in the cycle after clock edge 16*(SETTLE+1), counted from the edge that samples start (SETTLE=1 gives edge 32).
REQ-025 start asserted in WAIT, SAMPLE or FIN SHALL be ignored.
REQ-026 abort=1 in any state SHALL:
- go to IDLE on the next edge with busy=0 and no done pulse;
- leave tt, ones, mismatch and err_idx holding their partial values.
REQ-027 abort and start high together in IDLE SHALL leave the FSM in IDLE.
REQ-028 tt, ones, mismatch and err_idx SHALL hold their values in IDLE until the next accepted start.
REQ-029 ones SHALL be 5 bits wide so that a count of 16 does not overflow.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force:
- state to IDLE;
- idx, x1..x4, tt, ones, err_idx to 0;
- busy, done, mismatch to 0.
REQ-032 Assertion of rst mid-sweep SHALL discard the sweep with no done pulse.
REQ-033 After rst deasserts, the first accepted start SHALL be the one sampled on the first rising edge with rst=0.

Verification
REQ-034 Nominal sweep:
- stimulus: evaluator with minterms {3,5,7,8..15}, exp_tt=16'hFFA8, SETTLE=1, one start pulse;
- response: done at edge 32, tt=16'hFFA8, ones=11, mismatch=0.
REQ-035 Mismatch capture:
- stimulus: same evaluator, exp_tt=16'hFFA0;
- response: mismatch=1, err_idx=3, tt=16'hFFA8, ones=11.
REQ-036 Full-count boundary:
- stimulus: f_in tied to 1, exp_tt=16'hFFFF;
- response: tt=16'hFFFF, ones=16, mismatch=0.
REQ-037 Settle timing:
- stimulus: SETTLE=3;
- response: x1..x4 stable for 3 cycles before each sample, done at edge 64, each vector's tt bit correct.
REQ-038 Ignored start and abort:
- stimulus: start re-pulsed at idx 4, then abort at idx 9 with f_in=1;
- response: re-start has no effect, busy=0 one edge after abort, no done, tt=16'h01FF, ones=9.
REQ-039 Reset mid-sweep:
- stimulus: rst asserted at idx 6;
- response: all outputs 0 immediately, without waiting for a clock edge; a later start runs a complete 16-vector sweep.

Source files
------------

// File: rtl/kmap_sweep_ctrl.sv
// Truth-table sweep controller: steps a 4-variable evaluator through all 16 input
// vectors, lets each settle, then captures f into a table with count and mismatch tracking.
module kmap_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_tt,
    input  logic        f_in,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  ones,
    output logic        mismatch,
    output logic [3:0]  err_idx
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_tt;
    logic [4:0]  r_ones;
    logic        r_mis;
    logic [3:0]  r_err;
    logic        r_busy;
    logic        r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_tt    <= 16'd0;
            r_ones  <= 5'd0;
            r_mis   <= 1'b0;
            r_err   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort keeps the partial capture so software can inspect how far the sweep got.
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_idx   <= 4'd0;
                            r_cnt   <= 4'd0;
                            r_tt    <= 16'd0;
                            r_ones  <= 5'd0;
                            r_mis   <= 1'b0;
                            r_err   <= 4'd0;
                            r_busy  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_SAMPLE: begin
                        r_tt[r_idx] <= f_in;
                        r_ones      <= r_ones + {4'd0, f_in};
                        if ((f_in != exp_tt[r_idx]) && !r_mis) begin
                            r_mis <= 1'b1;
                            r_err <= r_idx;
                        end
                        // idx parks at 15 after the last vector instead of wrapping.
                        if (r_idx == 4'd15) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign {x1, x2, x3, x4} = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tt       = r_tt;
    assign ones     = r_ones;
    assign mismatch = r_mis;
    assign err_idx  = r_err;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a table-based
// evaluator model, results compared with truth-table arithmetic computed in the bench.
module tb_kmap_sweep_ctrl;

    localparam int SB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_abort = 0, a_f;
    logic [15:0] a_exp = 0, a_eval = 0;
    logic        a_x1, a_x2, a_x3, a_x4, a_busy, a_done, a_mis;
    logic [15:0] a_tt;
    logic [4:0]  a_ones;
    logic [3:0]  a_err;
    logic [3:0]  a_idx;

    logic        b_start = 0, b_abort = 0, b_f;
    logic [15:0] b_exp = 0, b_eval = 0;
    logic        b_x1, b_x2, b_x3, b_x4, b_busy, b_done, b_mis;
    logic [15:0] b_tt;
    logic [4:0]  b_ones;
    logic [3:0]  b_err;
    logic [3:0]  b_idx;

    assign a_idx = {a_x1, a_x2, a_x3, a_x4};
    assign b_idx = {b_x1, b_x2, b_x3, b_x4};
    always_comb a_f = a_eval[a_idx];
    always_comb b_f = b_eval[b_idx];

    kmap_sweep_ctrl #(.SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .exp_tt(a_exp), .f_in(a_f),
        .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .busy(a_busy), .done(a_done),
        .tt(a_tt), .ones(a_ones), .mismatch(a_mis), .err_idx(a_err)
    );

    kmap_sweep_ctrl #(.SETTLE(SB)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .exp_tt(b_exp), .f_in(b_f),
        .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .busy(b_busy), .done(b_done),
        .tt(b_tt), .ones(b_ones), .mismatch(b_mis), .err_idx(b_err)
    );

    int checks = 0;
    int errors = 0;

    function automatic int popcnt(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_diff(input logic [15:0] t, input logic [15:0] e);
        for (int i = 0; i < 16; i++) if (t[i] != e[i]) return i;
        return 0;
    endfunction

    // Vectors already captured n edges after the start edge, given s settle cycles.
    function automatic logic [15:0] sampled_mask(input int n, input int s);
        logic [15:0] m = '0;
        for (int k = 0; k < 16; k++) if ((k + 1) * (s + 1) <= n) m[k] = 1'b1;
        return m;
    endfunction

    // Called on a negedge; returns the edge count (from the start-sampling edge) at which done rose.
    task automatic run_a(output int n);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (a_done) break;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL run_a_timeout got no done want done within 1000 cycles");
            n = -1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({a_busy, a_done, a_mis, a_tt, a_ones, a_err, a_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b mis=%b tt=%h ones=%0d err=%0d idx=%0d want all 0",
                     a_busy, a_done, a_mis, a_tt, a_ones, a_err, a_idx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int n;
        a_eval = 16'hFFA8; a_exp = 16'hFFA8;
        @(negedge clk);
        run_a(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL nominal_done_edge got %0d want 32", n); end
        checks++; if (a_tt !== 16'hFFA8) begin errors++; $display("FAIL nominal_tt got %h want ffa8", a_tt); end
        checks++; if (a_ones !== 5'd11) begin errors++; $display("FAIL nominal_ones got %0d want 11", a_ones); end
        checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL nominal_mismatch got %b want 0", a_mis); end
        checks++; if (a_idx !== 4'hF) begin errors++; $display("FAIL nominal_idx_hold got %0d want 15", a_idx); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL nominal_done_width got %b want 0", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_idle got %b want 0", a_busy); end
    endtask

    task automatic test_mismatch();
        int n;
        a_eval = 16'hFFA8; a_exp = 16'hFFA0;
        run_a(n);
        checks++; if (a_mis !== 1'b1) begin errors++; $display("FAIL mm_flag got %b want 1", a_mis); end
        checks++; if (a_err !== 4'd3) begin errors++; $display("FAIL mm_err_idx got %0d want 3", a_err); end
        checks++; if (a_tt !== 16'hFFA8) begin errors++; $display("FAIL mm_tt got %h want ffa8", a_tt); end
        checks++; if (a_ones !== 5'd11) begin errors++; $display("FAIL mm_ones got %0d want 11", a_ones); end
        @(negedge clk);
    endtask

    task automatic test_full_count();
        int n;
        a_eval = 16'hFFFF; a_exp = 16'hFFFF;
        run_a(n);
        checks++; if (a_tt !== 16'hFFFF) begin errors++; $display("FAIL full_tt got %h want ffff", a_tt); end
        checks++; if (a_ones !== 5'd16) begin errors++; $display("FAIL full_ones got %0d want 16", a_ones); end
        checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL full_mismatch got %b want 0", a_mis); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        logic [15:0] t, e;
        for (int it = 0; it < 8; it++) begin
            t = 16'($urandom);
            e = (it % 3 == 0) ? t : (t ^ 16'($urandom));
            a_eval = t; a_exp = e;
            run_a(n);
            checks++; if (n !== 32) begin errors++; $display("FAIL rand_done_edge[%0d] got %0d want 32", it, n); end
            checks++; if (a_tt !== t) begin errors++; $display("FAIL rand_tt[%0d] got %h want %h", it, a_tt, t); end
            checks++;
            if (int'(a_ones) !== popcnt(t)) begin
                errors++; $display("FAIL rand_ones[%0d] got %0d want %0d", it, a_ones, popcnt(t));
            end
            checks++;
            if (a_mis !== (t != e)) begin errors++; $display("FAIL rand_mis[%0d] got %b want %b", it, a_mis, t != e); end
            if (t != e) begin
                checks++;
                if (int'(a_err) !== first_diff(t, e)) begin
                    errors++; $display("FAIL rand_err_idx[%0d] got %0d want %0d", it, a_err, first_diff(t, e));
                end
            end
            // Results must survive idle cycles and a start that is overridden by abort.
            a_eval = ~t;
            repeat (3) @(negedge clk);
            a_start = 1'b1; a_abort = 1'b1;
            @(negedge clk);
            a_start = 1'b0; a_abort = 1'b0;
            @(negedge clk);
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rand_start_abort_busy got %b want 0", a_busy); end
            checks++; if (a_tt !== t) begin errors++; $display("FAIL rand_hold_tt[%0d] got %h want %h", it, a_tt, t); end
        end
    endtask

    task automatic test_settle();
        logic [15:0] t, m;
        int exp_idx;
        t = 16'($urandom);
        b_eval = t; b_exp = t;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int n = 0; n <= 16 * (SB + 1) + 1; n++) begin
            if (n > 0) @(negedge clk);
            exp_idx = (n / (SB + 1) > 15) ? 15 : n / (SB + 1);
            m = sampled_mask(n, SB);
            checks++;
            if (int'(b_idx) !== exp_idx) begin errors++; $display("FAIL settle_idx[n=%0d] got %0d want %0d", n, b_idx, exp_idx); end
            checks++;
            if (b_busy !== (n < 16 * (SB + 1))) begin
                errors++; $display("FAIL settle_busy[n=%0d] got %b want %b", n, b_busy, n < 16 * (SB + 1));
            end
            checks++;
            if (b_done !== (n == 16 * (SB + 1))) begin
                errors++; $display("FAIL settle_done[n=%0d] got %b want %b", n, b_done, n == 16 * (SB + 1));
            end
            checks++;
            if (b_tt !== (t & m)) begin errors++; $display("FAIL settle_tt[n=%0d] got %h want %h", n, b_tt, t & m); end
            checks++;
            if (int'(b_ones) !== popcnt(t & m)) begin
                errors++; $display("FAIL settle_ones[n=%0d] got %0d want %0d", n, b_ones, popcnt(t & m));
            end
        end
    endtask

    task automatic test_ignored_start_abort();
        int w;
        a_eval = 16'hFFFF; a_exp = 16'hFFFF;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        w = 0;
        while (a_idx != 4'd4 && w < 100) begin @(negedge clk); w++; end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if (a_idx !== 4'd4 || a_busy !== 1'b1) begin
            errors++; $display("FAIL restart_ignored got idx=%0d busy=%b want idx=4 busy=1", a_idx, a_busy);
        end
        w = 0;
        while (a_idx != 4'd9 && w < 100) begin @(negedge clk); w++; end
        checks++; if (w >= 100) begin errors++; $display("FAIL abort_wait_idx9 got timeout want idx 9"); end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", a_busy); end
        checks++; if (a_tt !== 16'h01FF) begin errors++; $display("FAIL abort_tt got %h want 01ff", a_tt); end
        checks++; if (a_ones !== 5'd9) begin errors++; $display("FAIL abort_ones got %0d want 9", a_ones); end
        w = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (a_done || a_busy) w++; end
        checks++; if (w !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", w); end
        checks++; if (a_tt !== 16'h01FF) begin errors++; $display("FAIL abort_hold_tt got %h want 01ff", a_tt); end
    endtask

    task automatic test_reset_mid_sweep();
        int n, w;
        logic [15:0] t;
        a_eval = 16'hFFFF; a_exp = 16'h0000;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        w = 0;
        while (a_idx != 4'd6 && w < 100) begin @(negedge clk); w++; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_busy, a_done, a_mis, a_tt, a_ones, a_err, a_idx} !== '0) begin
            errors++;
            $display("FAIL midrst_async got busy=%b mis=%b tt=%h ones=%0d err=%0d idx=%0d want all 0",
                     a_busy, a_mis, a_tt, a_ones, a_err, a_idx);
        end
        t = 16'($urandom);
        a_eval = t; a_exp = t;
        @(negedge clk);
        rst = 1'b0;
        run_a(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL midrst_restart_edge got %0d want 32", n); end
        checks++; if (a_tt !== t) begin errors++; $display("FAIL midrst_restart_tt got %h want %h", a_tt, t); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_full_count();
        test_random();
        test_settle();
        test_ignored_start_abort();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
